// File: rtl/search_pkg.sv
// Shared widths, sentinel value and FSM encoding for the
// search job sequencer and its watchdog.
package search_pkg;

    localparam int PW    = 8;
    localparam int BW    = 8;
    localparam int LW    = 16;
    localparam int CYC_W = 16;

    localparam logic [LW-1:0] NO_MATCH = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_RUN    = 3'd2,
        S_REPORT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // A job the engine could never match is answered without running it.
    function automatic logic is_degenerate(
        input logic [PW-1:0] pl,
        input logic [LW-1:0] bl
    );
        return (pl == '0) || (bl == '0) || (LW'(pl) > bl);
    endfunction

endpackage

// File: rtl/search_scheduler_if.sv
// Job, engine and result signals of the search scheduler.
// slave = scheduler side, master = requester/engine/consumer side.
interface search_scheduler_if;
    import search_pkg::*;

    logic             job_valid;
    logic             job_ready;
    logic [PW-1:0]    job_p;
    logic [PW-1:0]    job_pl;
    logic [BW-1:0]    job_b;
    logic [LW-1:0]    job_bl;

    logic [PW-1:0]    eng_p;
    logic [PW-1:0]    eng_pl;
    logic [BW-1:0]    eng_b;
    logic [LW-1:0]    eng_bl;
    logic             eng_activate;
    logic             eng_reset;
    logic             eng_done;
    logic [LW-1:0]    eng_found;

    logic             res_valid;
    logic             res_ready;
    logic [LW-1:0]    res_addr;
    logic             res_last;
    logic             res_err;
    logic [CYC_W-1:0] res_cycles;
    logic             busy;

    modport slave (
        input  job_valid, job_p, job_pl, job_b, job_bl,
        input  eng_done, eng_found, res_ready,
        output job_ready,
        output eng_p, eng_pl, eng_b, eng_bl,
        output eng_activate, eng_reset,
        output res_valid, res_addr, res_last, res_err,
        output res_cycles, busy
    );

    modport master (
        output job_valid, job_p, job_pl, job_b, job_bl,
        output eng_done, eng_found, res_ready,
        input  job_ready,
        input  eng_p, eng_pl, eng_b, eng_bl,
        input  eng_activate, eng_reset,
        input  res_valid, res_addr, res_last, res_err,
        input  res_cycles, busy
    );

endinterface

// File: rtl/search_watchdog.sv
// Clearable cycle counter that flags when TIMEOUT cycles have
// elapsed; it parks at TIMEOUT until cleared.
module search_watchdog #(
    parameter int TIMEOUT = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = (cnt_q == CW'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/search_scheduler.sv
// Job sequencer for the search engine: runs one job, steps the
// engine through each match and hands every hit to the consumer.
module search_scheduler
    import search_pkg::*;
#(
    parameter int MAX_HITS = 16,
    parameter int TIMEOUT  = 65535
) (
    input  logic                CLK100MHZ,
    input  logic                reset,
    search_scheduler_if.slave   bus
);

    localparam int HW = $clog2(MAX_HITS + 1);

    state_t           state_q, state_d;
    logic [PW-1:0]    p_q, p_d;
    logic [PW-1:0]    pl_q, pl_d;
    logic [BW-1:0]    b_q, b_d;
    logic [LW-1:0]    bl_q, bl_d;
    logic [LW-1:0]    addr_q, addr_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [HW-1:0]    hits_q, hits_d;
    logic [HW-1:0]    hits_inc;
    logic             wd_clear;
    logic             wd_expired;
    logic             in_run;

    assign in_run   = (state_q == S_RUN);
    assign hits_inc = hits_q + 1'b1;

    search_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (CLK100MHZ),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (in_run),
        .expired (wd_expired)
    );

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        pl_d     = pl_q;
        b_d      = b_q;
        bl_d     = bl_q;
        addr_d   = addr_q;
        last_d   = last_q;
        err_d    = err_q;
        cyc_d    = cyc_q;
        hits_d   = hits_q;
        wd_clear = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.job_valid) begin
                    p_d    = bus.job_p;
                    pl_d   = bus.job_pl;
                    b_d    = bus.job_b;
                    bl_d   = bus.job_bl;
                    cyc_d  = '0;
                    hits_d = '0;
                    err_d  = 1'b0;
                    last_d = 1'b0;
                    if (is_degenerate(bus.job_pl, bus.job_bl)) begin
                        addr_d  = NO_MATCH;
                        last_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                wd_clear = 1'b1;
                state_d  = S_RUN;
            end
            S_RUN: begin
                // A real answer from the engine beats a same-cycle timeout.
                if (bus.eng_done) begin
                    err_d   = 1'b0;
                    addr_d  = bus.eng_found;
                    state_d = S_REPORT;
                    if (bus.eng_found != NO_MATCH) begin
                        hits_d = hits_inc;
                        last_d = (hits_inc == HW'(MAX_HITS));
                    end else begin
                        last_d = 1'b1;
                    end
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    last_d  = 1'b1;
                    addr_d  = NO_MATCH;
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                if (bus.res_ready) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        wd_clear = 1'b1;
                        state_d  = S_RUN;
                    end
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Elapsed time excludes cycles spent waiting on the consumer.
        if ((state_q == S_START || in_run) && cyc_q != '1) begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            pl_q    <= '0;
            b_q     <= '0;
            bl_q    <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= '0;
            hits_q  <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            pl_q    <= pl_d;
            b_q     <= b_d;
            bl_q    <= bl_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            hits_q  <= hits_d;
        end
    end

    assign bus.job_ready    = (state_q == S_IDLE) && !reset;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.eng_reset    = reset || (state_q == S_START);
    assign bus.eng_activate = in_run;
    assign bus.eng_p        = p_q;
    assign bus.eng_pl       = pl_q;
    assign bus.eng_b        = b_q;
    assign bus.eng_bl       = bl_q;
    assign bus.res_valid    = (state_q == S_REPORT) ||
                              (state_q == S_DONE);
    assign bus.res_addr     = addr_q;
    assign bus.res_last     = last_q;
    assign bus.res_err      = err_q;
    assign bus.res_cycles   = cyc_q;

endmodule
